// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - instruction format enum, opcode constants and format decode
package instr_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Unknown opcodes fall back to R so the raw fields still reach the word.
    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_OP, OP_OP_32:                       return FMT_R;
            OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR:   return FMT_I;
            OP_STORE:                              return FMT_S;
            OP_BRANCH:                             return FMT_B;
            OP_LUI, OP_AUIPC:                      return FMT_U;
            OP_JAL:                                return FMT_J;
            default:                               return FMT_R;
        endcase
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        case (op)
            OP_OP, OP_OP_32, OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR,
            OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// rtl/instr_enc_fifo.sv - DEPTH x W synchronous FIFO with occupancy, full and empty
module instr_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A full FIFO refuses the push even if a pop frees a slot this cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointer/occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RISC-V field packer feeding an output FIFO; INSTR_ENC_CHECK_EN adds bundle rejection
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef INSTR_ENC_CHECK_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 funct3,
    input  logic [6:0]                 funct7,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [4:0]                 rd,
    input  logic [31:0]                imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                instruction,
    output logic [$clog2(DEPTH):0]     count
`ifdef INSTR_ENC_CHECK_EN
    ,
    output logic                       err,
    output logic [CNT_W-1:0]           err_count
`endif
);

    fmt_e        fmt;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        full;
    logic        empty;

    assign fmt    = fmt_of(opcode);
    assign accept = in_valid & in_ready;

    // Pack the fields according to the decoded format; imm bits outside the slice are dropped.
    always_comb begin
        word = '0;
        case (fmt)
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    logic             reject;
    logic             err_q;
    logic [CNT_W-1:0] err_count_q;

    // Rejected bundles are consumed by the handshake but never reach the FIFO.
    assign reject = ~op_known(opcode) | (((fmt == FMT_B) | (fmt == FMT_J)) & imm[0]);
    assign push   = accept & ~reject;

    // One-cycle error pulse and saturating reject counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q <= accept & reject;
            if (accept && reject && (err_count_q != '1))
                err_count_q <= err_count_q + 1'b1;
        end
    end

    assign err       = err_q;
    assign err_count = err_count_q;
`else
    assign push = accept;
`endif

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (word),
        .pop_i   (out_ready),
        .rdata_o (instruction),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign in_ready  = ~full;
    assign out_valid = ~empty;

endmodule
